// File: rtl/regex_char_source.sv
// Serializes a packed bit string onto the regex matcher's character line and
// collects match statistics from the matcher output while the string drains.
module regex_char_source #(
    parameter int WORD_W     = 32,
    parameter int LEN_W      = 6,
    parameter int DRAIN_CYC  = 24,
    parameter int START_HOLD = 0,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic [LEN_W-1:0]  in_len,
    output logic              i,
    output logic              i_c,
    input  logic              m,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  match_cnt,
    output logic [CNT_W-1:0]  first_pos,
    output logic              matched
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam int DRN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    logic [1:0]        state;
    logic [WORD_W-1:0] sh;
    logic [LEN_W-1:0]  bit_cnt;
    logic [DRN_W-1:0]  drn_cnt;
    logic [CNT_W-1:0]  pos;
    logic [LEN_W-1:0]  len_cl;
    logic              sampling;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        len_cl = in_len;
        if (in_len > LEN_W'(WORD_W))
            len_cl = LEN_W'(WORD_W);
    end

    // in_ready is a pure state decode, so in_valid never reaches it combinationally
    assign in_ready = (state == IDLE);
    assign sampling = (state == SHIFT) || (state == DRAIN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sh        <= '0;
            bit_cnt   <= '0;
            drn_cnt   <= '0;
            pos       <= '0;
            i         <= 1'b0;
            i_c       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            match_cnt <= '0;
            first_pos <= '0;
            matched   <= 1'b0;
        end else begin
            done <= 1'b0;

            // Matcher output is only meaningful while a string or its drain is in flight
            if (sampling) begin
                pos <= sat_inc(pos);
                if (m) begin
                    match_cnt <= sat_inc(match_cnt);
                    if (!matched) begin
                        first_pos <= pos;
                        matched   <= 1'b1;
                    end
                end
            end

            case (state)
                IDLE: begin
                    if (in_valid) begin
                        match_cnt <= '0;
                        first_pos <= '0;
                        matched   <= 1'b0;
                        pos       <= '0;
                        busy      <= 1'b1;
                        sh        <= in_data >> 1;
                        bit_cnt   <= len_cl;
                        if (len_cl != '0) begin
                            state <= SHIFT;
                            i     <= 1'b1;
                            i_c   <= in_data[0];
                        end else begin
                            state   <= DRAIN;
                            drn_cnt <= DRN_W'(DRAIN_CYC - 1);
                        end
                    end
                end
                SHIFT: begin
                    if (bit_cnt == LEN_W'(1)) begin
                        state   <= DRAIN;
                        i       <= 1'b0;
                        i_c     <= 1'b0;
                        drn_cnt <= DRN_W'(DRAIN_CYC - 1);
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                        sh      <= sh >> 1;
                        i_c     <= sh[0];
                        i       <= (START_HOLD != 0);
                    end
                end
                DRAIN: begin
                    if (drn_cnt == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drn_cnt <= drn_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regex_char_source.sv
// Directed bench for regex_char_source: serialization, drain timing, match
// statistics, clamping, back-to-back handshake and mid-string reset.
module tb_regex_char_source;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [5:0]  in_len;
    logic        i;
    logic        i_c;
    logic        m;
    logic        busy;
    logic        done;
    logic [7:0]  match_cnt;
    logic [7:0]  first_pos;
    logic        matched;

    int n_checks = 0;
    int n_err    = 0;

    regex_char_source #(
        .WORD_W(32), .LEN_W(6), .DRAIN_CYC(24), .START_HOLD(0), .CNT_W(8)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_len(in_len), .i(i), .i_c(i_c), .m(m),
        .busy(busy), .done(done), .match_cnt(match_cnt), .first_pos(first_pos),
        .matched(matched)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sends one string, pulses m at positions mp0/mp1 (-1 = none), checks the
    // serialized bits, timing and the results at the done cycle and one cycle later.
    task automatic run_str(input string tag, input logic [31:0] data, input int len,
                           input int mp0, input int mp1,
                           input int exp_cnt, input int exp_first, input int exp_match);
        int eff;
        logic [31:0] ic_obs;
        logic [31:0] mask;
        int i_hi, i_first, busy_n, done_k, ic_after;
        eff = (len > 32) ? 32 : len;
        mask = (eff == 32) ? 32'hFFFF_FFFF : ((32'd1 << eff) - 32'd1);
        ic_obs = '0; i_hi = 0; i_first = 0; busy_n = 0; done_k = 0; ic_after = 0;
        @(negedge clk);
        in_data  = data;
        in_len   = 6'(len);
        in_valid = 1'b1;
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int k = 1; k <= 80 && done_k == 0; k++) begin
            @(negedge clk);
            m = ((k - 1) == mp0) || ((k - 1) == mp1);
            if (k <= eff) ic_obs[k-1] = i_c;
            else if (i_c) ic_after++;
            if (i) begin
                i_hi++;
                if (k == 1) i_first = 1;
            end
            if (busy) busy_n++;
            if (done) done_k = k;
        end
        check({tag, "_ic_bits"},  ic_obs, data & mask);
        check({tag, "_ic_after"}, 32'(ic_after), 32'd0);
        check({tag, "_i_count"},  32'(i_hi), (eff > 0) ? 32'd1 : 32'd0);
        check({tag, "_i_first"},  32'(i_first), (eff > 0) ? 32'd1 : 32'd0);
        check({tag, "_busy_n"},   32'(busy_n), 32'(eff + 24));
        check({tag, "_done_lat"}, 32'(done_k), 32'(eff + 25));
        check({tag, "_cnt"},      32'(match_cnt), 32'(exp_cnt));
        check({tag, "_first"},    32'(first_pos), 32'(exp_first));
        check({tag, "_matched"},  32'(matched), 32'(exp_match));
        @(negedge clk);
        m = 1'b0;
        check({tag, "_done_1cyc"}, 32'(done), 32'd0);
        check({tag, "_cnt_hold"},  32'(match_cnt), 32'(exp_cnt));
    endtask

    initial begin
        int done_k, rdy_busy, done_seen;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_len = '0; m = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready",   32'(in_ready), 32'd1);
        check("rst_i",       32'(i), 32'd0);
        check("rst_ic",      32'(i_c), 32'd0);
        check("rst_busy",    32'(busy), 32'd0);
        check("rst_done",    32'(done), 32'd0);
        check("rst_cnt",     32'(match_cnt), 32'd0);
        check("rst_first",   32'(first_pos), 32'd0);
        check("rst_matched", 32'(matched), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(in_ready), 32'd1);

        // Basic string, no matches; then matches at 5 and 9; then position 0 plus
        // a pulse in the DONE cycle (position 27) that must be ignored.
        run_str("t2", 32'h5, 3, -1, -1, 0, 0, 0);
        run_str("t3", 32'h5, 3, 5, 9, 2, 5, 1);
        run_str("t3b", 32'h5, 3, 0, 27, 1, 0, 1);
        run_str("t4", 32'hFFFF_FFFF, 0, 3, -1, 1, 3, 1);
        run_str("t5", 32'hA5C3_1E7F, 40, 31, 55, 2, 31, 1);
        run_str("t5b", 32'h8000_0001, 32, -1, -1, 0, 0, 0);

        // Back-to-back with in_valid held and m high through the first string
        @(negedge clk);
        in_data = 32'h1; in_len = 6'd1; in_valid = 1'b1; m = 1'b1;
        @(posedge clk);
        #1 in_data = 32'h2; in_len = 6'd2;
        done_k = 0; rdy_busy = 0;
        for (int k = 1; k <= 60 && done_k == 0; k++) begin
            @(negedge clk);
            if (in_ready) rdy_busy++;
            if (done) done_k = k;
        end
        check("b2b_lat1",    32'(done_k), 32'd26);
        check("b2b_rdy_busy", 32'(rdy_busy), 32'd0);
        check("b2b_cnt1",    32'(match_cnt), 32'd25);
        check("b2b_first1",  32'(first_pos), 32'd0);
        m = 1'b0;
        @(negedge clk);
        check("b2b_idle_rdy", 32'(in_ready), 32'd1);
        check("b2b_idle_cnt", 32'(match_cnt), 32'd25);
        @(negedge clk);
        check("b2b_t2_rdy",   32'(in_ready), 32'd0);
        check("b2b_t2_cnt",   32'(match_cnt), 32'd0);
        check("b2b_t2_match", 32'(matched), 32'd0);
        check("b2b_t2_busy",  32'(busy), 32'd1);
        check("b2b_t2_i",     32'(i), 32'd1);
        check("b2b_t2_ic",    32'(i_c), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b_t2_bit1",  32'(i_c), 32'd1);
        check("b2b_t2_i2",    32'(i), 32'd0);
        done_k = 0;
        for (int k = 3; k <= 60 && done_k == 0; k++) begin
            @(negedge clk);
            if (done) done_k = k;
        end
        check("b2b_lat2", 32'(done_k), 32'd27);

        // Reset during the 4th SHIFT cycle aborts the string
        @(negedge clk);
        in_data = 32'hFF; in_len = 6'd8; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        m = 1'b1;
        @(negedge clk);
        m = 1'b0;
        @(negedge clk);
        check("ab_matched_pre", 32'(matched), 32'd1);
        @(negedge clk);
        check("ab_ic_pre",   32'(i_c), 32'd1);
        check("ab_busy_pre", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("ab_i",     32'(i), 32'd0);
        check("ab_ic",    32'(i_c), 32'd0);
        check("ab_busy",  32'(busy), 32'd0);
        check("ab_ready", 32'(in_ready), 32'd1);
        check("ab_matched", 32'(matched), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        check("ab_no_done", 32'(done_seen), 32'd0);
        check("ab_cnt",     32'(match_cnt), 32'd0);
        check("ab_first",   32'(first_pos), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
